pcb_skew_line: RTL and testbench
================================

Name: pcb_skew_line

Overview:
- Parametrised, synthesisable successor to the fixed board-delay model. Sits between tester and DUT in the bench; reusable in the FPGA tester image.
- Carries NCH independent channels of W bits each.
- Each channel's latency is programmable at run time from 1 to MAX_DLY+1 clock cycles.
- Adds per-channel lock/valid tracking and stuck-value fault injection.

Parameters:
- NCH, 4, number of channels.
- W, 16, bits per channel.
- MAX_DLY, 15, largest programmable delay value; buffer depth per channel.
- DLY_W, 4, width of a delay field; must satisfy 2^DLY_W > MAX_DLY.
- DLY_INIT, 0, delay loaded into every channel at reset.

Ports:
- CLK  in  1  sole clock.
- RST  in  1  synchronous reset, active-high.
- DIN  in  NCH*W  input samples; channel c occupies bits [c*W +: W].
- DOUT  out  NCH*W  delayed samples, registered.
- DOUT_VLD  out  NCH  channel output is locked to its current delay.
- CFG_WE  in  1  single-cycle delay write strobe.
- CFG_CH  in  clog2(NCH)  channel selected for write and readback.
- CFG_DLY  in  DLY_W  requested delay value.
- CFG_ERR  out  1  one-cycle pulse: request out of range.
- CFG_RDATA  out  DLY_W  current delay of CFG_CH (combinational readback).
- FORCE_EN  in  NCH  fault injection enable per channel.
- FORCE_VAL  in  W  value forced onto enabled channels.

Behaviour:
- Reset (RST high at a CLK edge):
  - wptr=0; every dly[c]=DLY_INIT; fill counters=0.
  - DOUT=0; DOUT_VLD=0; CFG_ERR=0.
  - Buffer contents are not reset.
  - RST wins over CFG_WE in the same cycle.
- Buffer: one circular buffer per channel, depth MAX_DLY, with a write pointer shared by all channels. Each cycle:
  - mem[c][wptr] <= DIN_c.
  - wptr <= (wptr==MAX_DLY-1) ? 0 : wptr+1.
- Read, with d = dly[c]: DOUT_c <= (d==0) ? DIN_c : mem[c][(wptr-d) mod MAX_DLY].
  - The read returns the old contents before the same-edge write, so d=MAX_DLY is legal.
  - Total latency DIN->DOUT is d+1 cycles.
  - Modulo arithmetic uses DLY_W+1 bits and adds MAX_DLY on underflow. Wrap-around must be seamless.
- Fault injection:
  - FORCE_EN[c]=1: DOUT_c <= FORCE_VAL on the next edge. The buffer keeps writing and DOUT_VLD is unaffected.
  - On release, the delayed stream resumes the next cycle with no relock.
- Lock tracking, per channel:
  - fill[c] increments each cycle and saturates at MAX_DLY+1.
  - DOUT_VLD[c] <= (fill[c] >= dly[c]). DOUT_VLD therefore rises on the same edge DOUT first carries a sample captured after reset or reconfig.
  - While DOUT_VLD[c]=0, DOUT_c holds its previous value (0 after reset) instead of presenting buffer data. FORCE_EN still overrides this hold.
- Configuration write (CFG_WE=1):
  - If CFG_DLY <= MAX_DLY: dly[CFG_CH] <= CFG_DLY, fill[CFG_CH] <= 0, DOUT_VLD[CFG_CH] <= 0 on the same edge. Relock occurs d_new+1 cycles later.
  - If CFG_DLY > MAX_DLY: the delay saturates to MAX_DLY, CFG_ERR pulses high for 1 cycle, and the relock proceeds as for a legal write.
  - If CFG_CH >= NCH: the write is ignored and CFG_ERR pulses.
  - A write of the current value still forces a relock.
  - Back-to-back writes to the same channel: the last one wins and its relock restarts.
  - Writes to different channels never disturb other channels.
- No throughput stalls: one sample per channel per cycle, always.

Decomposition:
- Shared package pcb_pkg: clog2 function, default NCH/W/MAX_DLY constants, channel slice macro helpers.
- One sub-module, skew_chan: buffer, read mux, fill counter, hold and force logic for a single channel, instantiated NCH times by a generate loop.
- The top level holds wptr, the config decode and CFG_ERR.

Test Plan:
- Reset then DIN_0 = cycle count, DLY_INIT=0 -> DOUT_0 = count-1; DOUT_VLD=4'b1111 one cycle after RST falls.
- Write ch2 delay 15 while ch2 is running -> DOUT_VLD[2] low for 16 cycles, DOUT_2 frozen; then DOUT_2 = DIN_2 delayed 16 cycles; ch0, ch1 and ch3 unchanged throughout.
- Hold ch1 at delay 7 for 100 cycles (multiple wptr wraps) -> no dropped or repeated sample, latency exactly 8.
- CFG_DLY=20 to ch3 -> CFG_ERR pulse of 1 cycle; CFG_RDATA reads 15.
- FORCE_EN=4'b0100, FORCE_VAL=16'hDEAD for 5 cycles -> DOUT_2=DEAD on cycles 1..5; delayed stream back on cycle 6; DOUT_VLD[2] stays 1.
- RST asserted together with CFG_WE mid-run -> all delays = DLY_INIT, DOUT=0, DOUT_VLD=0, no CFG_ERR.

Source files
------------

// File: rtl/pcb_skew_line_pkg.sv
// Shared constants and helpers for the per-channel skew line.
// Channel slices are taken with the PCB_CH macro below.
package pcb_pkg;

    localparam int NCH_DEF     = 4;
    localparam int W_DEF       = 16;
    localparam int MAX_DLY_DEF = 15;
    localparam int DLY_W_DEF   = 4;

    // never returns 0 so it can size a vector directly
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++)
            if ((1 << i) < n)
                r = i + 1;
        return r;
    endfunction

endpackage

`define PCB_CH(v, c, w) v[(c)*(w) +: (w)]

// File: rtl/pcb_skew_line_if.sv
// Tester-facing bundle of the skew line: data, config and fault injection.
interface pcb_skew_line_if
    import pcb_pkg::*;
#(
    parameter int NCH   = NCH_DEF,
    parameter int W     = W_DEF,
    parameter int DLY_W = DLY_W_DEF,
    parameter int CW    = clog2(NCH)
);

    logic [NCH*W-1:0] DIN;
    logic [NCH*W-1:0] DOUT;
    logic [NCH-1:0]   DOUT_VLD;
    logic             CFG_WE;
    logic [CW-1:0]    CFG_CH;
    logic [DLY_W-1:0] CFG_DLY;
    logic             CFG_ERR;
    logic [DLY_W-1:0] CFG_RDATA;
    logic [NCH-1:0]   FORCE_EN;
    logic [W-1:0]     FORCE_VAL;

    modport master (
        output DIN, CFG_WE, CFG_CH, CFG_DLY, FORCE_EN, FORCE_VAL,
        input  DOUT, DOUT_VLD, CFG_ERR, CFG_RDATA
    );

    modport slave (
        input  DIN, CFG_WE, CFG_CH, CFG_DLY, FORCE_EN, FORCE_VAL,
        output DOUT, DOUT_VLD, CFG_ERR, CFG_RDATA
    );

endinterface

// File: rtl/pcb_skew_line_chan.sv
// One delay channel: circular buffer, read mux, lock tracking,
// output hold while unlocked and stuck-value override.
module skew_chan
    import pcb_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int MAX_DLY  = MAX_DLY_DEF,
    parameter int DLY_W    = DLY_W_DEF,
    parameter int DLY_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic [DLY_W-1:0] wptr,
    input  logic             cfg_we,
    input  logic [DLY_W-1:0] cfg_dly,
    input  logic             force_en,
    input  logic [W-1:0]     force_val,
    output logic [W-1:0]     dout,
    output logic             vld,
    output logic [DLY_W-1:0] dly
);

    localparam int AW = clog2(MAX_DLY);
    localparam logic [DLY_W:0] FILL_MAX = (DLY_W+1)'(MAX_DLY + 1);

    logic [W-1:0]   mem [MAX_DLY];
    logic [DLY_W:0] fill;
    logic [DLY_W:0] diff;
    logic [DLY_W:0] rd;
    logic [AW-1:0]  ra;
    logic [AW-1:0]  wa;
    logic           lock;

    // read slot is (wptr - dly) mod MAX_DLY, corrected on borrow
    always_comb begin
        diff = {1'b0, wptr} - {1'b0, dly};
        rd   = diff[DLY_W] ? diff + (DLY_W+1)'(MAX_DLY) : diff;
        ra   = AW'(rd);
        wa   = AW'(wptr);
        lock = fill >= {1'b0, dly};
    end

    always_ff @(posedge clk) begin
        mem[wa] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dly  <= DLY_W'(DLY_INIT);
            fill <= '0;
            vld  <= 1'b0;
            dout <= '0;
        end else begin
            if (cfg_we) begin
                dly  <= cfg_dly;
                fill <= '0;
                vld  <= 1'b0;
            end else begin
                if (fill != FILL_MAX)
                    fill <= fill + 1'b1;
                vld <= lock;
            end
            // unlocked channels hold their last output
            if (force_en)
                dout <= force_val;
            else if (!cfg_we && lock)
                dout <= (dly == '0) ? din : mem[ra];
        end
    end

endmodule

// File: rtl/pcb_skew_line.sv
// NCH-channel programmable board-delay line with lock tracking
// and fault injection; owns the shared write pointer and config decode.
module pcb_skew_line
    import pcb_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int W        = W_DEF,
    parameter int MAX_DLY  = MAX_DLY_DEF,
    parameter int DLY_W    = DLY_W_DEF,
    parameter int DLY_INIT = 0
) (
    input logic             CLK,
    input logic             RST,
    pcb_skew_line_if.slave  bus
);

    localparam int CW = clog2(NCH);

    logic [DLY_W-1:0] wptr;
    logic [DLY_W-1:0] dly_sat;
    logic [DLY_W-1:0] dly_a  [NCH];
    logic [W-1:0]     dout_a [NCH];
    logic [NCH-1:0]   vld_a;
    logic [NCH*W-1:0] dout_pk;
    logic [DLY_W-1:0] rdata;
    logic             ch_ok;
    logic             dly_big;
    logic             cfg_err;

    always_ff @(posedge CLK) begin
        if (RST)
            wptr <= '0;
        else
            wptr <= (wptr == DLY_W'(MAX_DLY - 1)) ? '0 : wptr + 1'b1;
    end

    always_comb begin
        ch_ok   = int'(bus.CFG_CH) < NCH;
        dly_big = int'(bus.CFG_DLY) > MAX_DLY;
        dly_sat = dly_big ? DLY_W'(MAX_DLY) : bus.CFG_DLY;
    end

    always_ff @(posedge CLK) begin
        if (RST)
            cfg_err <= 1'b0;
        else
            cfg_err <= bus.CFG_WE && (!ch_ok || dly_big);
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        skew_chan #(
            .W        (W),
            .MAX_DLY  (MAX_DLY),
            .DLY_W    (DLY_W),
            .DLY_INIT (DLY_INIT)
        ) u_chan (
            .clk       (CLK),
            .rst       (RST),
            .din       (`PCB_CH(bus.DIN, c, W)),
            .wptr      (wptr),
            .cfg_we    (bus.CFG_WE && ch_ok && bus.CFG_CH == CW'(c)),
            .cfg_dly   (dly_sat),
            .force_en  (bus.FORCE_EN[c]),
            .force_val (bus.FORCE_VAL),
            .dout      (dout_a[c]),
            .vld       (vld_a[c]),
            .dly       (dly_a[c])
        );
    end

    always_comb begin
        dout_pk = '0;
        rdata   = '0;
        for (int c = 0; c < NCH; c++) begin
            `PCB_CH(dout_pk, c, W) = dout_a[c];
            if (bus.CFG_CH == CW'(c))
                rdata = dly_a[c];
        end
    end

    assign bus.DOUT      = dout_pk;
    assign bus.DOUT_VLD  = vld_a;
    assign bus.CFG_ERR   = cfg_err;
    assign bus.CFG_RDATA = rdata;

endmodule

// File: tb/tb_pcb_skew_line.sv
// Bench for pcb_skew_line: cycle scoreboard from a history-based model
// plus a table of delay writes and hand-written force/reset sequences.
module tb_pcb_skew_line;
    import pcb_pkg::*;

    localparam int NCH      = 4;
    localparam int W        = 16;
    localparam int MAX_DLY  = 15;
    localparam int DLY_W    = 5;
    localparam int DLY_INIT = 0;
    localparam int CW       = clog2(NCH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pcb_skew_line_if #(.NCH(NCH), .W(W), .DLY_W(DLY_W)) bus ();

    pcb_skew_line #(
        .NCH(NCH), .W(W), .MAX_DLY(MAX_DLY),
        .DLY_W(DLY_W), .DLY_INIT(DLY_INIT)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    typedef struct {
        logic [NCH*W-1:0] dout;
        logic [NCH-1:0]   vld;
        logic             err;
        logic [DLY_W-1:0] rdata;
    } exp_t;

    typedef struct {
        int   ch;
        int   dly;
        logic err;
        int   rdata;
        int   gap;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[8];

    int n_chk  = 0;
    int n_fail = 0;
    int ecnt   = 0;

    logic [W-1:0] hist [NCH][2048];
    int           m_dly [NCH];
    int           cfg_edge [NCH];
    logic [W-1:0] m_dout [NCH];
    logic         m_vld [NCH];

    function automatic logic [W-1:0] din_at(int e, int c);
        return W'(e * 7 + c * 4096 + 1);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)",
                     name, got, exp, ecnt);
        end
    endtask

    // drive DIN, predict this edge, then compare after it
    task automatic step();
        exp_t         e;
        exp_t         g;
        logic [W-1:0] dv;
        logic         wr;
        for (int c = 0; c < NCH; c++) begin
            dv = din_at(ecnt, c);
            hist[c][ecnt] = dv;
            bus.DIN[c*W +: W] = dv;
        end
        if (rst) begin
            e.err = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                m_dly[c]    = DLY_INIT;
                cfg_edge[c] = ecnt;
                m_vld[c]    = 1'b0;
                m_dout[c]   = '0;
            end
        end else begin
            e.err = bus.CFG_WE && (int'(bus.CFG_CH) >= NCH ||
                                   int'(bus.CFG_DLY) > MAX_DLY);
            for (int c = 0; c < NCH; c++) begin
                wr = bus.CFG_WE && int'(bus.CFG_CH) == c;
                if (wr) begin
                    m_dly[c] = (int'(bus.CFG_DLY) > MAX_DLY) ?
                               MAX_DLY : int'(bus.CFG_DLY);
                    cfg_edge[c] = ecnt;
                    m_vld[c] = 1'b0;
                end else begin
                    m_vld[c] = (ecnt - cfg_edge[c]) > m_dly[c];
                    if (m_vld[c] && !bus.FORCE_EN[c])
                        m_dout[c] = hist[c][ecnt - m_dly[c]];
                end
                if (bus.FORCE_EN[c])
                    m_dout[c] = bus.FORCE_VAL;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e.dout[c*W +: W] = m_dout[c];
            e.vld[c] = m_vld[c];
        end
        e.rdata = DLY_W'(m_dly[bus.CFG_CH]);
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("dout", 64'(bus.DOUT), 64'(g.dout));
        chk("dout_vld", 64'(bus.DOUT_VLD), 64'(g.vld));
        chk("cfg_err", 64'(bus.CFG_ERR), 64'(g.err));
        chk("cfg_rdata", 64'(bus.CFG_RDATA), 64'(g.rdata));
        ecnt++;
    endtask

    initial begin
        int low;
        tbl[0] = '{2, 15, 1'b0, 15, 25};
        tbl[1] = '{1,  7, 1'b0,  7, 100};
        tbl[2] = '{3, 20, 1'b1, 15, 20};
        tbl[3] = '{0,  3, 1'b0,  3, 0};
        tbl[4] = '{0,  5, 1'b0,  5, 10};
        tbl[5] = '{1,  7, 1'b0,  7, 12};
        tbl[6] = '{3,  0, 1'b0,  0, 4};
        tbl[7] = '{2, 16, 1'b1, 15, 20};

        bus.DIN       = '0;
        bus.CFG_WE    = 1'b0;
        bus.CFG_CH    = '0;
        bus.CFG_DLY   = '0;
        bus.FORCE_EN  = '0;
        bus.FORCE_VAL = '0;

        rst = 1'b1;
        step();
        step();
        chk("rst_dout", 64'(bus.DOUT), 64'h0);
        chk("rst_vld", 64'(bus.DOUT_VLD), 64'h0);
        rst = 1'b0;

        step();
        chk("vld_after_rst", 64'(bus.DOUT_VLD), 64'hF);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("d0_pass", 64'(bus.DOUT[W-1:0]), 64'(din_at(ecnt - 1, 0)));
        end

        foreach (tbl[i]) begin
            bus.CFG_WE  = 1'b1;
            bus.CFG_CH  = CW'(tbl[i].ch);
            bus.CFG_DLY = DLY_W'(tbl[i].dly);
            step();
            bus.CFG_WE = 1'b0;
            chk("tbl_err", 64'(bus.CFG_ERR), 64'(tbl[i].err));
            chk("tbl_rdata", 64'(bus.CFG_RDATA), 64'(tbl[i].rdata));
            low = bus.DOUT_VLD[tbl[i].ch] ? 0 : 1;
            for (int j = 0; j < tbl[i].gap; j++) begin
                step();
                if (!bus.DOUT_VLD[tbl[i].ch])
                    low++;
                if (j == 0)
                    chk("err_pulse_end", 64'(bus.CFG_ERR), 64'h0);
            end
            if (tbl[i].gap > tbl[i].rdata)
                chk("tbl_relock", 64'(low), 64'(tbl[i].rdata + 1));
        end

        bus.CFG_CH    = CW'(2);
        bus.FORCE_EN  = 4'b0100;
        bus.FORCE_VAL = 16'hDEAD;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("force_val", 64'(bus.DOUT[2*W +: W]), 64'hDEAD);
            chk("force_vld", 64'(bus.DOUT_VLD[2]), 64'h1);
        end
        bus.FORCE_EN  = '0;
        bus.FORCE_VAL = '0;
        step();
        chk("force_release", 64'(bus.DOUT[2*W +: W]),
            64'(din_at(ecnt - 1 - 15, 2)));
        for (int i = 0; i < 5; i++)
            step();

        bus.CFG_WE  = 1'b1;
        bus.CFG_CH  = CW'(3);
        bus.CFG_DLY = DLY_W'(20);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.CFG_WE = 1'b0;
        chk("rst_we_err", 64'(bus.CFG_ERR), 64'h0);
        chk("rst_we_dout", 64'(bus.DOUT), 64'h0);
        chk("rst_we_vld", 64'(bus.DOUT_VLD), 64'h0);
        chk("rst_we_rdata", 64'(bus.CFG_RDATA), 64'(DLY_INIT));
        step();
        chk("rst_we_relock", 64'(bus.DOUT_VLD), 64'hF);
        for (int i = 0; i < 4; i++)
            step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
